alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, 8, operand width of the shared ALU.
REQ-002 Parameter CMD_W, 4, ALU command width.
REQ-003 Parameter RES_W, 2*WIDTH, ALU result width.
REQ-004 Parameter LAT, 2, ALU cycles from the operand-sampling edge to a valid result; legal range is LAT >= 1.
REQ-005 CLK  in  1  single clock; all state updates on the rising edge.
REQ-006 RST  in  1  asynchronous, active-low reset.
REQ-007 REQ_VALID  in  2  per-requester request strobe, bit i = requester i.
REQ-008 REQ_READY  out  2  per-requester request accept.
REQ-009 REQ_OPA  in  2*WIDTH  operand A, packed {req1,req0}.
REQ-010 REQ_OPB  in  2*WIDTH  operand B, packed {req1,req0}.
REQ-011 REQ_CIN  in  2  carry-in per requester.
REQ-012 REQ_CMD  in  2*CMD_W  command, packed {req1,req0}.
REQ-013 REQ_MODE  in  2  arithmetic (1) or logical (0) mode per requester.
REQ-014 RSP_VALID  out  2  one-hot response valid; the set bit identifies the owning requester.
REQ-015 RSP_READY  in  2  per-requester response accept.
REQ-016 RSP_RES  out  RES_W  shared response result bus.
REQ-017 RSP_FLAGS  out  6  {COUT,OFLOW,G,E,L,ERR} captured from the ALU.
REQ-018 ALU_CE, ALU_OPA (WIDTH), ALU_OPB (WIDTH), ALU_CIN, ALU_CMD (CMD_W), ALU_MODE  out  drive the ALU clock enable, operands and control.
REQ-019 ALU_INP_VALID  out  2  ALU operand-valid field.
REQ-020 ALU_RES (RES_W), ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR  in  ALU outputs.
REQ-021 BUSY  out  1  high whenever the FSM is not in IDLE.

Function
REQ-022 The FSM SHALL use states IDLE, ISSUE, WAIT and RESP, and SHALL have at most one transaction in flight.
REQ-023 In IDLE with any REQ_VALID set, the arbiter SHALL combinationally assert REQ_READY for the winner only; the winner is the sole requester, or on a tie the requester not equal to register LAST.
REQ-024 On a REQ_VALID & REQ_READY edge, the arbiter SHALL latch the winner's OPA, OPB, CIN, CMD and MODE plus the owner id, and SHALL move to ISSUE.
REQ-025 ISSUE SHALL last exactly one cycle with ALU_CE=1, ALU_INP_VALID=2'b11 and the latched operands driven, SHALL load a counter with LAT, and SHALL then go to WAIT.
REQ-026 WAIT SHALL decrement the counter each cycle; on the edge where the counter is 1, RSP_RES/RSP_FLAGS SHALL capture the ALU outputs and the FSM SHALL go to RESP.
REQ-027 Accept-to-RSP_VALID latency SHALL be LAT+2 cycles.
REQ-028 In RESP, RSP_VALID[owner] SHALL be 1, and RSP_RES/RSP_FLAGS SHALL hold stable until RSP_READY[owner]=1; RSP_READY of the non-owner SHALL be ignored.
REQ-029 On the response handshake edge, LAST SHALL become owner and the FSM SHALL return to IDLE, so at least one IDLE cycle separates transactions.
REQ-030 Outside ISSUE, ALU_CE and ALU_INP_VALID SHALL be 0; the ALU operand outputs SHALL hold their latched values.
REQ-031 REQ_READY SHALL be 0 in every state except IDLE; a REQ_VALID withdrawn before acceptance SHALL be dropped without a grant.
REQ-032 The arbiter SHALL NOT decode CMD, and ALU_ERR SHALL be forwarded as data with no effect on the FSM.

Reset
REQ-033 While RST=0, the FSM SHALL be IDLE, LAST SHALL be 1 (requester 0 wins the first tie), and the counter, latches and every output SHALL be 0, asynchronously.
REQ-034 A reset asserted mid-transaction SHALL discard it, and no RSP_VALID for it SHALL appear after release.

Verification (WIDTH=8, LAT=2, ALU stub)
REQ-035 Req0 sends OPA=8'h0F, OPB=8'h01, CMD=0, MODE=1, CIN=0 -> one ALU_CE pulse carries these values; RSP_VALID=2'b01 four cycles after accept, with RSP_RES equal to the stub's 16'h0010.
REQ-036 Both requesters hold REQ_VALID continuously for four transactions after reset -> grant order 0,1,0,1.
REQ-037 RSP_READY held at 0 for 5 cycles in RESP while req1 is valid -> RSP_VALID, RSP_RES and RSP_FLAGS stay stable, BUSY=1 and REQ_READY=2'b00.
REQ-038 RST pulsed low during WAIT -> all outputs are 0 immediately and no RSP_VALID appears; the next request is served normally, with requester 0 winning a tie.
REQ-039 Stub returns ALU_ERR=1 -> RSP_FLAGS[0]=1 is delivered, and the next transaction proceeds normally.
REQ-040 Req1 raises REQ_VALID during req0's WAIT and drops it before IDLE -> req1 is never granted and REQ_READY[1] stays 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared multi-cycle ALU.
// Only one transaction is in flight. On a tie, the requester that was not served last wins.
module alu_arbiter #(
  parameter int WIDTH = 8,
  parameter int CMD_W = 4,
  parameter int RES_W = 2*WIDTH,
  parameter int LAT   = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [1:0]           REQ_VALID,
  output logic [1:0]           REQ_READY,
  input  logic [2*WIDTH-1:0]   REQ_OPA,
  input  logic [2*WIDTH-1:0]   REQ_OPB,
  input  logic [1:0]           REQ_CIN,
  input  logic [2*CMD_W-1:0]   REQ_CMD,
  input  logic [1:0]           REQ_MODE,
  output logic [1:0]           RSP_VALID,
  input  logic [1:0]           RSP_READY,
  output logic [RES_W-1:0]     RSP_RES,
  output logic [5:0]           RSP_FLAGS,
  output logic                 ALU_CE,
  output logic [WIDTH-1:0]     ALU_OPA,
  output logic [WIDTH-1:0]     ALU_OPB,
  output logic                 ALU_CIN,
  output logic [CMD_W-1:0]     ALU_CMD,
  output logic                 ALU_MODE,
  output logic [1:0]           ALU_INP_VALID,
  input  logic [RES_W-1:0]     ALU_RES,
  input  logic                 ALU_COUT,
  input  logic                 ALU_OFLOW,
  input  logic                 ALU_G,
  input  logic                 ALU_E,
  input  logic                 ALU_L,
  input  logic                 ALU_ERR,
  output logic                 BUSY
);

  localparam int CNT_W = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic               owner_q, owner_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               cin_q, cin_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [5:0]         flags_q, flags_d;
  logic [1:0]         grant;
  logic               win;
  logic               alu_ce;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      cin_q   <= 1'b0;
      cmd_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cin_q   <= cin_d;
      cmd_q   <= cmd_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  // A lone requester wins outright; when both request, the one not served last wins.
  assign win = (REQ_VALID == 2'b11) ? ~last_q : REQ_VALID[1];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cin_d   = cin_q;
    cmd_d   = cmd_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flags_d = flags_q;
    grant   = 2'b00;
    alu_ce  = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ_VALID != 2'b00) begin
          grant   = win ? 2'b10 : 2'b01;
          owner_d = win;
          opa_d   = win ? REQ_OPA[2*WIDTH-1:WIDTH] : REQ_OPA[WIDTH-1:0];
          opb_d   = win ? REQ_OPB[2*WIDTH-1:WIDTH] : REQ_OPB[WIDTH-1:0];
          cin_d   = REQ_CIN[win];
          cmd_d   = win ? REQ_CMD[2*CMD_W-1:CMD_W] : REQ_CMD[CMD_W-1:0];
          mode_d  = REQ_MODE[win];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        alu_ce  = 1'b1;
        cnt_d   = CNT_W'(LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          res_d   = ALU_RES;
          flags_d = {ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR};
          state_d = RESP;
        end
      end
      RESP: begin
        if (RSP_READY[owner_q]) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The grant is combinational from REQ_VALID, so it must be masked while reset is held.
  assign REQ_READY     = RST ? grant : 2'b00;
  assign RSP_VALID     = (state_q == RESP) ? {owner_q, ~owner_q} : 2'b00;
  assign RSP_RES       = res_q;
  assign RSP_FLAGS     = flags_q;
  assign ALU_CE        = alu_ce;
  assign ALU_INP_VALID = alu_ce ? 2'b11 : 2'b00;
  assign ALU_OPA       = opa_q;
  assign ALU_OPB       = opb_q;
  assign ALU_CIN       = cin_q;
  assign ALU_CMD       = cmd_q;
  assign ALU_MODE      = mode_q;
  assign BUSY          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two-stage ALU stub, transaction-level reference model checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_alu_arbiter;

  localparam int WIDTH = 8;
  localparam int CMD_W = 4;
  localparam int RES_W = 16;
  localparam int LAT   = 2;

  logic              CLK;
  logic              RST;
  logic [1:0]        REQ_VALID;
  logic [1:0]        REQ_READY;
  logic [15:0]       REQ_OPA;
  logic [15:0]       REQ_OPB;
  logic [1:0]        REQ_CIN;
  logic [7:0]        REQ_CMD;
  logic [1:0]        REQ_MODE;
  logic [1:0]        RSP_VALID;
  logic [1:0]        RSP_READY;
  logic [15:0]       RSP_RES;
  logic [5:0]        RSP_FLAGS;
  logic              ALU_CE;
  logic [7:0]        ALU_OPA;
  logic [7:0]        ALU_OPB;
  logic              ALU_CIN;
  logic [3:0]        ALU_CMD;
  logic              ALU_MODE;
  logic [1:0]        ALU_INP_VALID;
  logic [15:0]       ALU_RES;
  logic              ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR;
  logic              BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.WIDTH(WIDTH), .CMD_W(CMD_W), .RES_W(RES_W), .LAT(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB), .REQ_CIN(REQ_CIN),
    .REQ_CMD(REQ_CMD), .REQ_MODE(REQ_MODE),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS),
    .ALU_CE(ALU_CE), .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB), .ALU_CIN(ALU_CIN),
    .ALU_CMD(ALU_CMD), .ALU_MODE(ALU_MODE), .ALU_INP_VALID(ALU_INP_VALID),
    .ALU_RES(ALU_RES), .ALU_COUT(ALU_COUT), .ALU_OFLOW(ALU_OFLOW),
    .ALU_G(ALU_G), .ALU_E(ALU_E), .ALU_L(ALU_L), .ALU_ERR(ALU_ERR),
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stub ALU behaviour: {flags, result}; mode 1 adds with carry, mode 0 XORs; cmd F raises ERR.
  function automatic logic [21:0] stub_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin, input logic [3:0] cmd, input logic mode);
    logic [15:0] r;
    logic [5:0]  f;
    if (mode) r = 16'(a) + 16'(b) + 16'(cin);
    else      r = {8'h00, a ^ b};
    f = {r[8], 1'b0, (a > b), (a == b), (a < b), (cmd == 4'hF)};
    return {f, r};
  endfunction

  logic [21:0] stage1, stage2;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      if (ALU_CE) stage1 <= stub_fn(ALU_OPA, ALU_OPB, ALU_CIN, ALU_CMD, ALU_MODE);
      stage2 <= stage1;
    end
  end
  assign ALU_RES = stage2[15:0];
  assign {ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR} = stage2[21:16];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // Reference model: k counts clock edges since acceptance (0 = issue cycle).
  bit          m_busy;
  int          m_k;
  bit          m_owner, m_last;
  logic [7:0]  m_opa, m_opb;
  logic        m_cin, m_mode;
  logic [3:0]  m_cmd;
  logic [15:0] m_res;
  logic [5:0]  m_flags;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_busy = 0; m_k = 0; m_owner = 0; m_last = 1;
      m_opa = '0; m_opb = '0; m_cin = 0; m_mode = 0; m_cmd = '0;
      m_res = '0; m_flags = '0;
    end else if (m_busy) begin
      if (m_k >= LAT + 1 && RSP_READY[m_owner]) begin
        m_busy = 0;
        m_last = m_owner;
      end else begin
        m_k++;
      end
    end else if (REQ_VALID != 2'b00) begin
      m_owner = (REQ_VALID == 2'b11) ? ~m_last : REQ_VALID[1];
      m_opa   = REQ_OPA[m_owner*8 +: 8];
      m_opb   = REQ_OPB[m_owner*8 +: 8];
      m_cin   = REQ_CIN[m_owner];
      m_cmd   = REQ_CMD[m_owner*4 +: 4];
      m_mode  = REQ_MODE[m_owner];
      {m_flags, m_res} = stub_fn(m_opa, m_opb, m_cin, m_cmd, m_mode);
      m_busy = 1;
      m_k    = 0;
    end
  end

  function automatic logic [1:0] model_ready();
    if (m_busy || REQ_VALID == 2'b00) return 2'b00;
    if (REQ_VALID == 2'b11) return m_last ? 2'b01 : 2'b10;
    return REQ_VALID;
  endfunction

  always @(negedge CLK) begin
    logic [1:0] exp_rv;
    logic       exp_ce;
    if (!RST) begin
      check_output("rst_req_ready", REQ_READY, 2'b00);
      check_output("rst_rsp_valid", RSP_VALID, 2'b00);
      check_output("rst_busy", BUSY, 1'b0);
      check_output("rst_alu_ce", ALU_CE, 1'b0);
      check_output("rst_rsp_res", RSP_RES, 16'h0);
      check_output("rst_alu_opa", ALU_OPA, 8'h0);
    end else begin
      exp_ce = m_busy && (m_k == 0);
      exp_rv = (m_busy && m_k >= LAT + 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      check_output("m_req_ready", REQ_READY, model_ready());
      check_output("m_busy", BUSY, m_busy);
      check_output("m_alu_ce", ALU_CE, exp_ce);
      check_output("m_inp_valid", ALU_INP_VALID, exp_ce ? 2'b11 : 2'b00);
      check_output("m_rsp_valid", RSP_VALID, exp_rv);
      if (exp_rv != 2'b00) begin
        check_output("m_rsp_res", RSP_RES, m_res);
        check_output("m_rsp_flags", RSP_FLAGS, m_flags);
      end
      check_output("m_alu_opa", ALU_OPA, m_opa);
      check_output("m_alu_opb", ALU_OPB, m_opb);
      check_output("m_alu_ctl", {ALU_CIN, ALU_CMD, ALU_MODE}, {m_cin, m_cmd, m_mode});
    end
  end

  bit t7_on, t7_seen;
  always @(negedge CLK) if (t7_on && REQ_READY[1]) t7_seen = 1;

  task automatic apply_stimulus(input int r, input logic [7:0] a, input logic [7:0] b,
                                input logic cin, input logic [3:0] cmd, input logic mode);
    REQ_OPA[r*8 +: 8] = a;
    REQ_OPB[r*8 +: 8] = b;
    REQ_CIN[r]        = cin;
    REQ_CMD[r*4 +: 4] = cmd;
    REQ_MODE[r]       = mode;
    REQ_VALID[r]      = 1'b1;
  endtask

  task automatic drop_req(input int r);
    REQ_VALID[r] = 1'b0;
  endtask

  task automatic wait_ready(input int r);
    bit ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge CLK);
      if (REQ_READY[r]) ok = 1;
    end
    if (!ok) timeout_fail("wait_ready");
  endtask

  task automatic wait_rsp();
    bit ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge CLK);
      if (RSP_VALID != 2'b00) ok = 1;
    end
    if (!ok) timeout_fail("wait_rsp");
  endtask

  task automatic respond(input logic [1:0] rdy);
    RSP_READY = rdy;
    @(posedge CLK);
    #1 RSP_READY = 2'b00;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2 RST = 1'b0;
    @(posedge CLK);
    #3 RST = 1'b1;
  endtask

  initial begin
    int cyc, ce_count, gcnt, rsp_seen;
    int grants[4];
    bit got;

    RST = 1'b0;
    REQ_VALID = '0; REQ_OPA = '0; REQ_OPB = '0; REQ_CIN = '0;
    REQ_CMD = '0; REQ_MODE = '0; RSP_READY = '0;
    t7_on = 0; t7_seen = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_output("reset_busy", BUSY, 1'b0);
    check_output("reset_rsp_valid", RSP_VALID, 2'b00);
    @(posedge CLK);
    #3 RST = 1'b1;

    $display("[TB] single request from requester 0");
    @(posedge CLK);
    #1 apply_stimulus(0, 8'h0F, 8'h01, 1'b0, 4'h0, 1'b1);
    @(negedge CLK);
    check_output("t1_req_ready", REQ_READY, 2'b01);
    @(posedge CLK);
    #1 drop_req(0);
    got = 0; cyc = 0; ce_count = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge CLK);
      if (ALU_CE) begin
        ce_count++;
        check_output("t1_alu_opa", ALU_OPA, 8'h0F);
        check_output("t1_alu_opb", ALU_OPB, 8'h01);
        check_output("t1_alu_inp_valid", ALU_INP_VALID, 2'b11);
      end
      if (RSP_VALID != 2'b00) begin
        got = 1;
        cyc = i;
      end
    end
    check_output("t1_latency", cyc, 4);
    check_output("t1_ce_pulses", ce_count, 1);
    check_output("t1_rsp_valid", RSP_VALID, 2'b01);
    check_output("t1_rsp_res", RSP_RES, 16'h0010);
    check_output("t1_rsp_flags", RSP_FLAGS, 6'b001000);
    respond(2'b01);
    @(negedge CLK);
    check_output("t1_idle", BUSY, 1'b0);

    $display("[TB] both requesters continuously valid");
    do_reset();
    for (int i = 0; i < 4; i++) grants[i] = 2;
    RSP_READY = 2'b11;
    @(posedge CLK);
    #1;
    apply_stimulus(0, 8'h0A, 8'h14, 1'b0, 4'h0, 1'b1);
    apply_stimulus(1, 8'hF0, 8'h0F, 1'b1, 4'h2, 1'b0);
    gcnt = 0;
    for (int i = 0; i < 100 && gcnt < 4; i++) begin
      @(negedge CLK);
      if (REQ_READY != 2'b00) begin
        grants[gcnt] = REQ_READY[1];
        gcnt++;
      end
    end
    if (gcnt < 4) timeout_fail("t2_grants");
    @(posedge CLK);
    #1 REQ_VALID = 2'b00;
    check_output("t2_grant0", grants[0], 0);
    check_output("t2_grant1", grants[1], 1);
    check_output("t2_grant2", grants[2], 0);
    check_output("t2_grant3", grants[3], 1);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge CLK);
      if (!BUSY) got = 1;
    end
    if (!got) timeout_fail("t2_drain");
    RSP_READY = 2'b00;

    $display("[TB] response back-pressure with other requester waiting");
    @(posedge CLK);
    #1 apply_stimulus(0, 8'hC8, 8'h64, 1'b1, 4'h0, 1'b1);
    wait_ready(0);
    @(posedge CLK);
    #1;
    drop_req(0);
    apply_stimulus(1, 8'h33, 8'h11, 1'b0, 4'h1, 1'b0);
    RSP_READY = 2'b10;
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      check_output("t3_rsp_valid", RSP_VALID, 2'b01);
      check_output("t3_rsp_res", RSP_RES, 16'h012D);
      check_output("t3_rsp_flags", RSP_FLAGS, 6'b101000);
      check_output("t3_busy", BUSY, 1'b1);
      check_output("t3_req_ready", REQ_READY, 2'b00);
      @(negedge CLK);
    end
    respond(2'b01);
    wait_ready(1);
    check_output("t3_req1_grant", REQ_READY, 2'b10);
    @(posedge CLK);
    #1 drop_req(1);
    wait_rsp();
    check_output("t3_req1_rsp_valid", RSP_VALID, 2'b10);
    check_output("t3_req1_rsp_res", RSP_RES, 16'h0022);
    respond(2'b10);

    $display("[TB] reset during wait");
    @(posedge CLK);
    #1 apply_stimulus(0, 8'h01, 8'h02, 1'b0, 4'h0, 1'b1);
    wait_ready(0);
    @(posedge CLK);
    #1 drop_req(0);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    check_output("t4_rst_busy", BUSY, 1'b0);
    check_output("t4_rst_rsp_valid", RSP_VALID, 2'b00);
    check_output("t4_rst_alu_opa", ALU_OPA, 8'h00);
    check_output("t4_rst_alu_opb", ALU_OPB, 8'h00);
    check_output("t4_rst_rsp_res", RSP_RES, 16'h0000);
    check_output("t4_rst_rsp_flags", RSP_FLAGS, 6'h00);
    check_output("t4_rst_req_ready", REQ_READY, 2'b00);
    @(posedge CLK);
    #3 RST = 1'b1;
    rsp_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (RSP_VALID != 2'b00) rsp_seen++;
    end
    check_output("t4_no_stale_rsp", rsp_seen, 0);
    @(posedge CLK);
    #1;
    apply_stimulus(0, 8'h40, 8'h02, 1'b0, 4'h0, 1'b1);
    apply_stimulus(1, 8'h41, 8'h03, 1'b0, 4'h0, 1'b1);
    @(negedge CLK);
    check_output("t4_tie_after_reset", REQ_READY, 2'b01);
    @(posedge CLK);
    #1 REQ_VALID = 2'b00;
    wait_rsp();
    check_output("t4_rsp_valid", RSP_VALID, 2'b01);
    check_output("t4_rsp_res", RSP_RES, 16'h0042);
    respond(2'b01);

    $display("[TB] ALU error forwarded as data");
    @(posedge CLK);
    #1 apply_stimulus(0, 8'h05, 8'h03, 1'b0, 4'hF, 1'b0);
    wait_ready(0);
    @(posedge CLK);
    #1 drop_req(0);
    wait_rsp();
    check_output("t5_err_flag", RSP_FLAGS[0], 1'b1);
    check_output("t5_flags", RSP_FLAGS, 6'b001001);
    check_output("t5_res", RSP_RES, 16'h0006);
    respond(2'b01);
    @(posedge CLK);
    #1 apply_stimulus(1, 8'h03, 8'h03, 1'b0, 4'h0, 1'b1);
    wait_ready(1);
    @(posedge CLK);
    #1 drop_req(1);
    wait_rsp();
    check_output("t5_next_valid", RSP_VALID, 2'b10);
    check_output("t5_next_flags", RSP_FLAGS, 6'b000100);
    check_output("t5_next_res", RSP_RES, 16'h0006);
    respond(2'b10);

    $display("[TB] request withdrawn while busy");
    @(posedge CLK);
    #1 apply_stimulus(0, 8'h20, 8'h10, 1'b0, 4'h0, 1'b1);
    wait_ready(0);
    @(posedge CLK);
    #1;
    drop_req(0);
    t7_on = 1;
    @(posedge CLK);
    #1 apply_stimulus(1, 8'h77, 8'h11, 1'b0, 4'h0, 1'b1);
    @(posedge CLK);
    #1 drop_req(1);
    wait_rsp();
    check_output("t6_rsp_valid", RSP_VALID, 2'b01);
    check_output("t6_rsp_res", RSP_RES, 16'h0030);
    respond(2'b01);
    repeat (5) @(negedge CLK);
    t7_on = 0;
    check_output("t6_req1_never_ready", t7_seen, 1'b0);
    check_output("t6_idle_after", BUSY, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
